// File: rtl/reg_set_wr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_set_wr_arbiter
//
// Shares the register set's single write port between two requesters (A, B).
// Ownership is round-robin, with a per-requester lock that keeps ownership
// across back-to-back writes. The write port outputs are registered and
// drive the register set's wen / Wr_addr / d inputs directly.
//
// A requester's write is accepted on any edge where it owns the port and
// has req high. The captured address/data appear on the write port, with
// wr_en high, in the following cycle.
//
// Optional build macro:
//   REGSET_ARB_STATS_EN - adds the coll_cnt port. This is an 8-bit
//                         saturating count of edges where both requesters
//                         were requesting.
// ---------------------------------------------------------------------------
module reg_set_wr_arbiter #(
    parameter int N = 8,
    parameter int w = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_req,
    input  logic         a_lock,
    input  logic [w-1:0] a_addr,
    input  logic [N-1:0] a_data,
    output logic         a_gnt,
    input  logic         b_req,
    input  logic         b_lock,
    input  logic [w-1:0] b_addr,
    input  logic [N-1:0] b_data,
    output logic         b_gnt,
    output logic         wr_en,
    output logic [w-1:0] wr_addr,
    output logic [N-1:0] wr_data,
    output logic         busy
`ifdef REGSET_ARB_STATS_EN
    ,
    output logic [7:0]   coll_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_A = 2'b01,
        ST_OWN_B = 2'b10
    } state_t;

    // Saturating 8-bit increment used by the contention counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'hFF) begin
            res = val;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

    // Ownership decision when leaving an owned state.
    // own_req/own_lock belong to the current owner; oth_req belongs to the
    // other requester. The result encodes: 2'b00 = go idle, 2'b01 = stay,
    // 2'b10 = hand over.
    function automatic logic [1:0] own_decision(input logic own_req,
                                                input logic own_lock,
                                                input logic oth_req);
        logic [1:0] res;
        if (own_req && own_lock) begin
            res = 2'b01;
        end else if (oth_req) begin
            res = 2'b10;
        end else if (own_req) begin
            res = 2'b01;
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic           last_b_r;      // 1: B was granted most recently
    logic           accept_a_s;
    logic           accept_b_s;
    logic [1:0]     dec_a_s;
    logic [1:0]     dec_b_s;
    logic           a_gnt_r;
    logic           b_gnt_r;
    logic           busy_r;
    logic           wr_en_r;
    logic [w-1:0]   wr_addr_r;
    logic [N-1:0]   wr_data_r;

    assign dec_a_s = own_decision(a_req, a_lock, b_req);
    assign dec_b_s = own_decision(b_req, b_lock, a_req);

    // Next-state logic and write-acceptance decode from the registered state.
    always_comb begin
        state_next_s = state_r;
        accept_a_s   = 1'b0;
        accept_b_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (a_req && b_req) begin
                    // The tie goes to whoever was not granted last.
                    if (last_b_r) begin
                        state_next_s = ST_OWN_A;
                    end else begin
                        state_next_s = ST_OWN_B;
                    end
                end else if (a_req) begin
                    state_next_s = ST_OWN_A;
                end else if (b_req) begin
                    state_next_s = ST_OWN_B;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_OWN_A: begin
                accept_a_s = a_req;
                case (dec_a_s)
                    2'b01:   state_next_s = ST_OWN_A;
                    2'b10:   state_next_s = ST_OWN_B;
                    default: state_next_s = ST_IDLE;
                endcase
            end
            ST_OWN_B: begin
                accept_b_s = b_req;
                case (dec_b_s)
                    2'b01:   state_next_s = ST_OWN_B;
                    2'b10:   state_next_s = ST_OWN_A;
                    default: state_next_s = ST_IDLE;
                endcase
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, with grant and busy registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_gnt_r <= 1'b0;
            b_gnt_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            a_gnt_r <= (state_next_s == ST_OWN_A);
            b_gnt_r <= (state_next_s == ST_OWN_B);
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Tracks the most recently accepted requester for round-robin ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_r <= 1'b1;
        end else if (accept_a_s) begin
            last_b_r <= 1'b0;
        end else if (accept_b_s) begin
            last_b_r <= 1'b1;
        end else begin
            last_b_r <= last_b_r;
        end
    end

    // Write-port register: captures the accepted write and holds it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else if (accept_a_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= a_addr;
            wr_data_r <= a_data;
        end else if (accept_b_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= b_addr;
            wr_data_r <= b_data;
        end else begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
        end
    end

`ifdef REGSET_ARB_STATS_EN
    logic [7:0] coll_cnt_r;

    // Counts edges with both requesters active, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt_r <= 8'd0;
        end else if (a_req && b_req) begin
            coll_cnt_r <= sat_inc8(coll_cnt_r);
        end else begin
            coll_cnt_r <= coll_cnt_r;
        end
    end

    assign coll_cnt = coll_cnt_r;
`endif

    assign a_gnt   = a_gnt_r;
    assign b_gnt   = b_gnt_r;
    assign busy    = busy_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

endmodule

// File: tb/tb_reg_set_wr_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for reg_set_wr_arbiter.
// A behavioural model tracks the owner (0 = none, 1 = A, 2 = B), the
// last-granted requester and the expected write port. The DUT is compared
// to the model on every falling edge. Directed sequences with literal
// expectations pin the model, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_reg_set_wr_arbiter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_lock = 1'b0, b_req = 1'b0, b_lock = 1'b0;
    logic [2:0] a_addr = 3'd0, b_addr = 3'd0;
    logic [7:0] a_data = 8'd0, b_data = 8'd0;
    logic       a_gnt, b_gnt, wr_en, busy;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
`ifdef REGSET_ARB_STATS_EN
    logic [7:0] coll_cnt;
`endif

    int checks = 0;
    int errors = 0;

    reg_set_wr_arbiter #(.N(8), .w(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_lock(a_lock), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_lock(b_lock), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
`ifdef REGSET_ARB_STATS_EN
        , .coll_cnt(coll_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:1] req_v, lock_v;
    logic [2:0] addr_v [1:2];
    logic [7:0] data_v [1:2];
    always_comb begin
        req_v     = {b_req, a_req};
        lock_v    = {b_lock, a_lock};
        addr_v[1] = a_addr;
        addr_v[2] = b_addr;
        data_v[1] = a_data;
        data_v[2] = b_data;
    end

    int         m_owner, m_last, m_cnt;
    logic       m_wen;
    logic [2:0] m_addr;
    logic [7:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= 0;
            m_last  <= 2;
            m_wen   <= 1'b0;
            m_addr  <= 3'd0;
            m_data  <= 8'd0;
            m_cnt   <= 0;
        end else begin
            if (a_req && b_req && m_cnt < 255) m_cnt <= m_cnt + 1;
            if (m_owner == 0) begin
                m_wen <= 1'b0;
                if (req_v == 2'b11) m_owner <= 3 - m_last;
                else if (req_v[1])  m_owner <= 1;
                else if (req_v[2])  m_owner <= 2;
            end else begin
                if (req_v[m_owner]) begin
                    m_wen  <= 1'b1;
                    m_addr <= addr_v[m_owner];
                    m_data <= data_v[m_owner];
                    m_last <= m_owner;
                end else begin
                    m_wen <= 1'b0;
                end
                if (req_v[m_owner] && lock_v[m_owner]) m_owner <= m_owner;
                else if (req_v[3 - m_owner])           m_owner <= 3 - m_owner;
                else if (!req_v[m_owner])              m_owner <= 0;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        check("cmp_a_gnt", 32'(a_gnt), 32'(m_owner == 1));
        check("cmp_b_gnt", 32'(b_gnt), 32'(m_owner == 2));
        check("cmp_busy", 32'(busy), 32'(m_owner != 0));
        check("cmp_wr_en", 32'(wr_en), 32'(m_wen));
        check("cmp_wr_addr", 32'(wr_addr), 32'(m_addr));
        check("cmp_wr_data", 32'(wr_data), 32'(m_data));
`ifdef REGSET_ARB_STATS_EN
        check("cmp_coll_cnt", 32'(coll_cnt), 32'(m_cnt));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] tie_seq [0:3];

    initial begin
        tie_seq[0] = 3'b011; tie_seq[1] = 3'b101; tie_seq[2] = 3'b011; tie_seq[3] = 3'b101;

        // Reset held with A requesting: all outputs stay at zero.
        a_req = 1'b1; a_addr = 3'b001; a_data = 8'h0F;
        repeat (3) step();
        check("rst_a_gnt", 32'(a_gnt), 32'd0);
        check("rst_b_gnt", 32'(b_gnt), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        check("first_a_gnt", 32'(a_gnt), 32'd1);
        check("first_wr_en_low", 32'(wr_en), 32'd0);
        step();
        check("first_wr_en", 32'(wr_en), 32'd1);
        check("first_wr_addr", 32'(wr_addr), 32'h1);
        check("first_wr_data", 32'(wr_data), 32'h0F);

        // Requester drops: write stops and the arbiter returns to idle.
        a_req = 1'b0;
        step();
        check("drop_wr_en", 32'(wr_en), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_hold_addr", 32'(wr_addr), 32'h1);

        // Tie after reset: alternating writes, A first.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        a_req = 1'b1; a_addr = 3'b011; a_data = 8'h33;
        b_req = 1'b1; b_addr = 3'b101; b_data = 8'hF0;
        step();
        check("tie_a_first", 32'(a_gnt), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("tie_wr_en", 32'(wr_en), 32'd1);
            check("tie_wr_addr", 32'(wr_addr), 32'(tie_seq[k]));
        end

        // Lock: A keeps the port for three writes while B waits.
        a_lock = 1'b1;
        step();
        check("lock_addr1", 32'(wr_addr), 32'h3);
        step();
        check("lock_addr2", 32'(wr_addr), 32'h3);
        check("lock_b_starved", 32'(b_gnt), 32'd0);
        a_lock = 1'b0;
        step();
        check("lock_addr3", 32'(wr_addr), 32'h3);
        step();
        check("lock_then_b", 32'(wr_addr), 32'h5);
        check("lock_then_b_data", 32'(wr_data), 32'hF0);

        // Async reset in the middle of an A burst.
        b_req = 1'b0;
        step();
        check("burst_wr_en", 32'(wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wr_en", 32'(wr_en), 32'd0);
        check("async_a_gnt", 32'(a_gnt), 32'd0);
        a_req = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_wr_en1", 32'(wr_en), 32'd0);
        step();
        check("post_rst_wr_en2", 32'(wr_en), 32'd0);

        // Randomized phase, with occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            a_req  = ($urandom_range(99) < 65);
            b_req  = ($urandom_range(99) < 65);
            a_lock = ($urandom_range(99) < 30);
            b_lock = ($urandom_range(99) < 30);
            a_addr = 3'($urandom);
            b_addr = 3'($urandom);
            a_data = 8'($urandom);
            b_data = 8'($urandom);
            if ($urandom_range(299) == 0) begin
                #1;
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            step();
        end

        // Contention counter saturation.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        a_req = 1'b1; b_req = 1'b1; a_lock = 1'b0; b_lock = 1'b0;
        repeat (300) step();
`ifdef REGSET_ARB_STATS_EN
        check("coll_cnt_sat", 32'(coll_cnt), 32'd255);
`endif
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
